// File: rtl/q_update_ctrl.sv
// Sequencer for one Q-learning update loop: selects an action, waits out the
// datapath latency, writes the Q-RAM, then decides whether the episode/run ends.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | load the initial state, clear the step index
// SELECT | launch action select and Q-RAM read
// WAIT   | PIPE_LAT cycles for the action/reward/state delay line
// WRITE  | Q-RAM write-back
// CHECK  | episode-end decision (goal or step limit)
// FINISH | run complete, pulse done
module q_update_ctrl #(
    parameter int PIPE_LAT  = 2,
    parameter int MAX_STEPS = 64,
    parameter int EP_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [EP_W-1:0] num_episodes,
    input  logic            goal,
    output logic            st_load,
    output logic            act_en,
    output logic            q_we,
    output logic            busy,
    output logic            ep_done,
    output logic            done,
    output logic [7:0]      step_cnt,
    output logic [EP_W-1:0] ep_cnt
);

    localparam int WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(PIPE_LAT - 1);
    localparam logic [7:0]    STEP_LAST = 8'(MAX_STEPS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SELECT = 3'd2,
        WAIT   = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        FINISH = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic [EP_W-1:0] ep_target;
    logic            ep_end;
    logic            last_ep;

    assign ep_end  = goal || (step_cnt == STEP_LAST);
    assign last_ep = (ep_cnt + EP_W'(1)) == ep_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (start && !abort)
                state_nxt = (num_episodes == '0) ? FINISH : INIT;
        end else if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                INIT:    state_nxt = SELECT;
                SELECT:  state_nxt = WAIT;
                WAIT:    if (wait_cnt == '0) state_nxt = WRITE;
                WRITE:   state_nxt = CHECK;
                CHECK: begin
                    if (ep_end) state_nxt = last_ep ? FINISH : INIT;
                    else        state_nxt = SELECT;
                end
                FINISH:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // done/ep_done are suppressed by abort; the other strobes follow the state only
    always_comb begin
        st_load = (state == INIT);
        act_en  = (state == SELECT);
        q_we    = (state == WRITE);
        busy    = (state != IDLE);
        ep_done = (state == CHECK) && ep_end && !abort;
        done    = (state == FINISH) && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt  <= '0;
            ep_cnt    <= '0;
            ep_target <= '0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        step_cnt  <= '0;
                        ep_cnt    <= '0;
                        ep_target <= num_episodes;
                    end
                end
                INIT: begin
                    if (!abort) step_cnt <= '0;
                end
                SELECT: begin
                    wait_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    if (wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
                end
                CHECK: begin
                    if (!abort) begin
                        if (ep_end) ep_cnt   <= ep_cnt + EP_W'(1);
                        else        step_cnt <= step_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_q_update_ctrl.sv
// Directed bench for q_update_ctrl with PIPE_LAT=2, MAX_STEPS=4.
// Cycle c is the interval after the c-th rising edge following the start cycle.
module tb_q_update_ctrl;

    localparam int PIPE_LAT  = 2;
    localparam int MAX_STEPS = 4;
    localparam int EP_W      = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic            goal;
    logic [EP_W-1:0] num_episodes;
    logic            st_load, act_en, q_we, busy, ep_done, done;
    logic [7:0]      step_cnt;
    logic [EP_W-1:0] ep_cnt;

    int checks = 0;
    int errors = 0;
    int excl_bad = 0;

    q_update_ctrl #(.PIPE_LAT(PIPE_LAT), .MAX_STEPS(MAX_STEPS), .EP_W(EP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_episodes(num_episodes), .goal(goal),
        .st_load(st_load), .act_en(act_en), .q_we(q_we), .busy(busy),
        .ep_done(ep_done), .done(done), .step_cnt(step_cnt), .ep_cnt(ep_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && ($countones({st_load, act_en, q_we, ep_done, done}) > 1))
            excl_bad = excl_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outv();
        return 32'({st_load, act_en, q_we, ep_done, done, busy});
    endfunction

    // advance to the next cycle, inputs then driven #1 after the edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // one episode, goal at the 3rd CHECK (cycle 16)
    task automatic run_scn1(input string tag);
        logic [5:0] ev;
        num_episodes = 16'd1;
        start = 1'b1;
        goal  = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            next_cycle();
            start = 1'b0;
            goal  = (c == 16);
            @(negedge clk);
            ev = {c == 1, (c == 2) || (c == 7) || (c == 12),
                  (c == 5) || (c == 10) || (c == 15), c == 16, c == 17, c <= 17};
            chk($sformatf("%s_outs_c%0d", tag, c), outv(), 32'(ev));
            if (c == 17) begin
                chk($sformatf("%s_ep_cnt", tag), 32'(ep_cnt), 32'd1);
                chk($sformatf("%s_step_cnt", tag), 32'(step_cnt), 32'd2);
            end
        end
        goal = 1'b0;
    endtask

    initial begin
        int qn, sn, en, dn, cyc_done;
        logic got_done;

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        goal = 1'b0;
        num_episodes = '0;
        #12;
        chk("reset_outs", outv(), 32'd0);
        chk("reset_step_cnt", 32'(step_cnt), 32'd0);
        chk("reset_ep_cnt", 32'(ep_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // basic single-episode timing
        run_scn1("s1");

        // step limit, two episodes
        num_episodes = 16'd2;
        start = 1'b1;
        goal = 1'b0;
        qn = 0; sn = 0; en = 0;
        got_done = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            next_cycle();
            start = 1'b0;
            @(negedge clk);
            if (q_we) qn++;
            if (st_load) sn++;
            if (ep_done) begin
                en++;
                chk("s2_step_at_ep_done", 32'(step_cnt), 32'd3);
                chk("s2_qwe_per_episode", 32'(qn), 32'(4 * en));
            end
            if (done) begin
                got_done = 1'b1;
                chk("s2_qwe_total", 32'(qn), 32'd8);
                chk("s2_st_load_total", 32'(sn), 32'd2);
                chk("s2_ep_done_total", 32'(en), 32'd2);
                chk("s2_ep_cnt_at_done", 32'(ep_cnt), 32'd2);
            end
        end
        chk("s2_done_seen", 32'(got_done), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("s2_idle_outs", outv(), 32'd0);
        chk("s2_ep_cnt_hold", 32'(ep_cnt), 32'd2);
        chk("s2_step_cnt_hold", 32'(step_cnt), 32'd3);

        // zero episodes: straight to FINISH
        num_episodes = 16'd0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk("s3_finish_outs", outv(), 32'b000011);
        chk("s3_ep_cnt_cleared", 32'(ep_cnt), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("s3_idle_outs", outv(), 32'd0);

        // abort in WAIT of step 2 (cycle 8)
        num_episodes = 16'd1;
        start = 1'b1;
        goal = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            start = 1'b0;
            if (c == 8) abort = 1'b1;
            @(negedge clk);
        end
        chk("s4_in_wait", outv(), 32'b000001);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        chk("s4_idle_after_abort", outv(), 32'd0);
        qn = 0; dn = 0; en = 0;
        for (int i = 0; i < 30; i++) begin
            next_cycle();
            @(negedge clk);
            if (q_we) qn++;
            if (done) dn++;
            if (ep_done) en++;
        end
        chk("s4_no_qwe", 32'(qn), 32'd0);
        chk("s4_no_done", 32'(dn), 32'd0);
        chk("s4_no_ep_done", 32'(en), 32'd0);

        // start and num_episodes churn while busy
        num_episodes = 16'd2;
        start = 1'b1;
        goal = 1'b1;
        en = 0; dn = 0;
        cyc_done = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            next_cycle();
            start = (i % 2 == 0);
            num_episodes = 16'(7 + i);
            @(negedge clk);
            if (ep_done) en++;
            if (done) begin
                got_done = 1'b1;
                cyc_done = i + 1;
                start = 1'b0;
                chk("s5_ep_cnt_at_done", 32'(ep_cnt), 32'd2);
            end
        end
        goal = 1'b0;
        chk("s5_done_seen", 32'(got_done), 32'd1);
        chk("s5_done_cycle", 32'(cyc_done), 32'd13);
        chk("s5_ep_done_count", 32'(en), 32'd2);
        next_cycle();
        @(negedge clk);
        chk("s5_idle1", outv(), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("s5_idle2", outv(), 32'd0);

        // async reset during WRITE, then a fresh run
        num_episodes = 16'd1;
        start = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            start = 1'b0;
            @(negedge clk);
        end
        chk("s6_in_write", outv(), 32'b001001);
        #2;
        rst = 1'b1;
        #1;
        chk("s6_reset_outs", outv(), 32'd0);
        chk("s6_reset_step_cnt", 32'(step_cnt), 32'd0);
        chk("s6_reset_ep_cnt", 32'(ep_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_scn1("s6");

        chk("strobes_exclusive", 32'(excl_bad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
